// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction cache: FSM state encoding, line geometry and word select.
package rv32i_types;

  localparam int ICACHE_LINE_BYTES = 32;
  localparam int ICACHE_LINE_BITS  = ICACHE_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    FILL
  } icache_state_t;

  typedef logic [ICACHE_LINE_BITS-1:0] line_t;

  // Word 0 sits in the least significant 32 bits of the line.
  function automatic logic [31:0] line_word(input line_t line, input logic [2:0] sel);
    return line[{sel, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: valid/tag/data per set, one-cycle synchronous read, write-first bypass.
module icache_line_array
  import rv32i_types::*;
#(
  parameter int SETS    = 16,
  parameter int IDXW    = $clog2(SETS),
  parameter int TAGW    = 32 - 5 - IDXW,
  parameter int RST_TAG = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic            rd_valid_o,
  output logic [TAGW-1:0] rd_tag_o,
  output line_t           rd_data_o,
  input  logic            we_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i,
  input  line_t           wr_data_i
);

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q [SETS];
  line_t           data_q [SETS];
  logic            rd_valid_q;
  logic [TAGW-1:0] rd_tag_q;
  line_t           rd_data_q;
  logic            bypass;

  assign bypass = we_i && (wr_idx_i == rd_idx_i);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= TAGW'(RST_TAG);
    end else begin
      if (we_i) valid_q[wr_idx_i] <= 1'b1;
      rd_valid_q <= bypass || valid_q[rd_idx_i];
      rd_tag_q   <= bypass ? wr_tag_i : tag_q[rd_idx_i];
    end
  end

  // NOTE: tag/data storage has no reset; the cleared valid bits make its contents irrelevant.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
    rd_data_q <= bypass ? wr_data_i : data_q[rd_idx_i];
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_responder.sv
// Blocking direct-mapped I-cache: answers imem fetches with one-cycle hits, refills lines from bmem.
module icache_responder
  import rv32i_types::*;
#(
  parameter int SETS        = 16,
  parameter int LINE_BEATS  = 4,
  parameter int RST_PC_LINE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [31:0] bmem_raddr,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - 5 - IDXW;
  localparam int CNTW = $clog2(LINE_BEATS);

  icache_state_t   state_q;
  logic [31:0]     req_addr_q;
  logic            req_v_q;
  logic [31:0]     miss_addr_q;
  logic [CNTW-1:0] cnt_q;
  logic [63:0]     beat_q [LINE_BEATS];

  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  line_t           rd_data;
  line_t           fill_line;
  logic            hit;
  logic            fill_beat;
  logic            last_beat;
  logic            line_we;

  assign hit       = req_v_q && rd_valid && (rd_tag == req_addr_q[31:5+IDXW]);
  assign fill_beat = (state_q == FILL) && bmem_rvalid && (bmem_raddr == miss_addr_q);
  assign last_beat = (cnt_q == CNTW'(LINE_BEATS - 1));
  assign line_we   = rst_n && fill_beat && last_beat;

  // The final beat goes straight into the array; earlier beats come from the buffer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fill_line = '0;
    for (int b = 0; b < LINE_BEATS - 1; b++) fill_line[64*b +: 64] = beat_q[b];
    fill_line[64*(LINE_BEATS-1) +: 64] = bmem_rdata;
  end

  icache_line_array #(
    .SETS    (SETS),
    .IDXW    (IDXW),
    .TAGW    (TAGW),
    .RST_TAG (RST_PC_LINE)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (imem_addr[4+IDXW:5]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (line_we),
    .wr_idx_i   (miss_addr_q[4+IDXW:5]),
    .wr_tag_i   (miss_addr_q[31:5+IDXW]),
    .wr_data_i  (fill_line)
  );

  // The request register tracks fetch in every state, so a redirect during a miss
  // simply replaces what gets looked up once the fill lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_v_q     <= 1'b0;
      miss_addr_q <= '0;
      cnt_q       <= '0;
    end else begin
      req_addr_q <= imem_addr;
      req_v_q    <= |imem_rmask;
      case (state_q)
        IDLE:   state_q <= LOOKUP;
        LOOKUP: if (req_v_q && !hit) begin
                  state_q     <= ISSUE;
                  miss_addr_q <= req_addr_q & ~32'(ICACHE_LINE_BYTES - 1);
                end
        ISSUE:  if (bmem_ready) begin
                  state_q <= FILL;
                  cnt_q   <= '0;
                end
        FILL:   if (fill_beat) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (last_beat) state_q <= LOOKUP;
                end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) beat_q[cnt_q] <= bmem_rdata;
  end

  assign imem_resp  = (state_q == LOOKUP) && hit;
  assign imem_rdata = imem_resp ? line_word(rd_data, req_addr_q[4:2]) : '0;
  assign bmem_read  = (state_q == ISSUE);
  assign bmem_addr  = bmem_read ? miss_addr_q : '0;

endmodule
